// File: rtl/jpeg_idct_transpose.sv
// Ping-pong transpose buffer between the row and column IDCT passes.
// Optional JPEG_IDCT_TRANSPOSE_SAT_EN saturates stored samples to signed 16 bits.
module jpeg_idct_transpose #(
  parameter int unsigned IN_SHIFT = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        img_start_i,
  input  logic        inport_valid_i,
  input  logic [31:0] inport_data_i,
  input  logic [5:0]  inport_idx_i,
  output logic        inport_accept_o,
  output logic        outport_valid_o,
  output logic [31:0] outport_data0_o,
  output logic [31:0] outport_data1_o,
  output logic [31:0] outport_data2_o,
  output logic [31:0] outport_data3_o,
  output logic [2:0]  outport_idx_o
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  logic signed [31:0] shifted;
  assign shifted = $signed(inport_data_i) >>> IN_SHIFT;

`ifdef JPEG_IDCT_TRANSPOSE_SAT_EN
  localparam int unsigned StoreW = 16;
  logic [StoreW-1:0] wr_data;
  always_comb begin
    if (shifted > 32'sd32767) begin
      wr_data = 16'h7fff;
    end else if (shifted < -32'sd32768) begin
      wr_data = 16'h8000;
    end else begin
      wr_data = shifted[15:0];
    end
  end
`else
  localparam int unsigned StoreW = 32;
  logic [StoreW-1:0] wr_data;
  assign wr_data = shifted;
`endif

  state_e            state_q;
  logic [1:0]        full_q;
  logic              wr_sel_q, rd_sel_q;
  logic [6:0]        wr_cnt_q;
  logic [5:0]        rd_cnt_q;
  logic              valid_q, zero_q;
  logic [2:0]        idx_q;
  logic [StoreW-1:0] mem_q   [4][32];
  logic [StoreW-1:0] rdata_q [4];

  logic       wr_fire, run, phase_odd;
  logic [2:0] phase, col;
  logic [4:0] wr_addr, rd_addr;

  assign inport_accept_o = ~full_q[wr_sel_q];
  assign wr_fire = inport_valid_i & inport_accept_o & ~img_start_i & ~rst_i;
  // Sub-array is row[2:1]; address inside the bank is {row[0], col}.
  assign wr_addr = {wr_sel_q, inport_idx_i[3], inport_idx_i[2:0]};

  assign run   = (state_q == StRun);
  assign col   = rd_cnt_q[5:3];
  assign phase = rd_cnt_q[2:0];
  // Column IDCT schedule: odd rows on phases 1, 3, 4; even rows on 0, 2, 5.
  assign phase_odd = (phase == 3'd1) | (phase == 3'd3) | (phase == 3'd4);
  assign rd_addr   = {rd_sel_q, phase_odd, col};

  always_ff @(posedge clk_i) begin
    if (wr_fire) begin
      mem_q[inport_idx_i[5:4]][wr_addr] <= wr_data;
    end
    for (int k = 0; k < 4; k++) begin
      rdata_q[k] <= mem_q[k][rd_addr];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || img_start_i) begin
      state_q  <= StIdle;
      full_q   <= 2'b00;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      wr_cnt_q <= 7'd0;
      rd_cnt_q <= 6'd0;
      valid_q  <= 1'b0;
      zero_q   <= 1'b1;
      idx_q    <= 3'd0;
    end else begin
      valid_q <= run;
      idx_q   <= phase;
      zero_q  <= ~run | (phase[2] & phase[1]);

      if (wr_fire) begin
        if (wr_cnt_q == 7'd63) begin
          full_q[wr_sel_q] <= 1'b1;
          wr_sel_q         <= ~wr_sel_q;
          wr_cnt_q         <= 7'd0;
        end else begin
          wr_cnt_q <= wr_cnt_q + 7'd1;
        end
      end

      unique case (state_q)
        StIdle: begin
          if (full_q[rd_sel_q]) begin
            state_q  <= StRun;
            rd_cnt_q <= 6'd0;
          end
        end
        StRun: begin
          rd_cnt_q <= rd_cnt_q + 6'd1;
          if (rd_cnt_q == 6'd63) begin
            full_q[rd_sel_q] <= 1'b0;
            rd_sel_q         <= ~rd_sel_q;
            if (!full_q[~rd_sel_q]) begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    outport_valid_o = valid_q;
    outport_idx_o   = idx_q;
    outport_data0_o = 32'd0;
    outport_data1_o = 32'd0;
    outport_data2_o = 32'd0;
    outport_data3_o = 32'd0;
    if (valid_q && !zero_q) begin
      outport_data0_o = 32'($signed(rdata_q[0]));
      outport_data1_o = 32'($signed(rdata_q[1]));
      outport_data2_o = 32'($signed(rdata_q[2]));
      outport_data3_o = 32'($signed(rdata_q[3]));
    end
  end

endmodule

// File: tb/tb_jpeg_idct_transpose.sv
// Directed bench for jpeg_idct_transpose; a second instance runs with IN_SHIFT = 2.
module tb_jpeg_idct_transpose;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        img_start = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic [5:0]  in_idx = '0;
  logic        acc, vld, acc_s, vld_s;
  logic [31:0] d0, d1, d2, d3, s0, s1, s2, s3;
  logic [2:0]  oidx, oidx_s;

  always #5 clk = ~clk;

  jpeg_idct_transpose #(.IN_SHIFT(0)) u_dut (
    .clk_i(clk), .rst_i(rst), .img_start_i(img_start),
    .inport_valid_i(in_valid), .inport_data_i(in_data), .inport_idx_i(in_idx),
    .inport_accept_o(acc), .outport_valid_o(vld),
    .outport_data0_o(d0), .outport_data1_o(d1), .outport_data2_o(d2), .outport_data3_o(d3),
    .outport_idx_o(oidx)
  );

  jpeg_idct_transpose #(.IN_SHIFT(2)) u_dut_sh (
    .clk_i(clk), .rst_i(rst), .img_start_i(img_start),
    .inport_valid_i(in_valid), .inport_data_i(in_data), .inport_idx_i(in_idx),
    .inport_accept_o(acc_s), .outport_valid_o(vld_s),
    .outport_data0_o(s0), .outport_data1_o(s1), .outport_data2_o(s2), .outport_data3_o(s3),
    .outport_idx_o(oidx_s)
  );

  typedef struct packed {
    int unsigned cyc;
    logic [2:0]   idx;
    logic [127:0] d;
  } beat_t;

  beat_t       q[$];
  beat_t       qs[$];
  int unsigned cyc = 0;
  int          acc_cnt = 0;
  bit          acc_hist [4096];
  int          acc_cnt_hist [4096];
  logic [31:0] exp_blk [64];
  int          errors = 0;
  int          checks = 0;
  int unsigned last_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (vld) q.push_back({cyc, oidx, d0, d1, d2, d3});
    if (vld_s) qs.push_back({cyc, oidx_s, s0, s1, s2, s3});
    if (cyc < 4096) begin
      acc_hist[cyc]     = acc;
      acc_cnt_hist[cyc] = acc_cnt;
    end
    if (in_valid && acc && !img_start && !rst) acc_cnt++;
  end

  task automatic check(input string tag, input logic [130:0] got, input logic [130:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected beat b of a block: column b/8, phase b%8, from exp_blk (row*8+col).
  function automatic logic [130:0] exp_beat(input int b);
    int           col, ph, odd;
    logic [127:0] d;
    logic [2:0]   p3;
    col = b / 8;
    ph  = b % 8;
    odd = (ph == 1 || ph == 3 || ph == 4) ? 1 : 0;
    p3  = ph[2:0];
    d   = '0;
    if (ph < 6) begin
      for (int k = 0; k < 4; k++) d[127-32*k -: 32] = exp_blk[(2*k+odd)*8+col];
    end
    return {p3, d};
  endfunction

  task automatic check_blk(input string tag, input bit shq, input int off);
    beat_t bt;
    int    sz;
    sz = shq ? qs.size() : q.size();
    check({tag, "_len"}, 131'(sz >= off + 64), 131'(1));
    if (sz >= off + 64) begin
      for (int b = 0; b < 64; b++) begin
        bt = shq ? qs[off+b] : q[off+b];
        check($sformatf("%s_b%0d", tag, b), {bt.idx, bt.d}, exp_beat(b));
      end
    end
  endtask

  task automatic send(input logic [5:0] idx, input logic [31:0] data);
    in_valid = 1'b1;
    in_idx   = idx;
    in_data  = data;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (acc) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        last_acc = cyc;
        return;
      end
    end
    check("send_timeout", 131'(0), 131'(1));
    in_valid = 1'b0;
  endtask

  task automatic wait_beats(input string tag, input int n);
    for (int t = 0; t < 400 && q.size() < n; t++) @(posedge clk);
    #1;
    check({tag, "_wait"}, 131'(q.size() >= n), 131'(1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int base, bad, n_rst;

  initial begin
    do_reset();
    check("rst_valid", 131'(vld), 131'(0));
    check("rst_idx", 131'(oidx), 131'(0));
    check("rst_data", 131'({d0, d1, d2, d3}), 131'(0));
    check("rst_accept", 131'(acc), 131'(1));

    // 1: in-order block, data = idx
    base = q.size();
    for (int i = 0; i < 64; i++) send(6'(i), 32'(i));
    wait_beats("t1", base + 64);
    repeat (10) @(posedge clk);
    #1;
    check("t1_count", 131'(q.size()), 131'(base + 64));
    check("t1_latency", 131'(q[base].cyc), 131'(last_acc + 2));
    check("t1_contig", 131'(q[base+63].cyc - q[base].cyc), 131'(63));
    check("t1_c0p0", {q[base].idx, q[base].d}, {3'd0, 128'h00000000_00000010_00000020_00000030});
    check("t1_c0p1", {q[base+1].idx, q[base+1].d}, {3'd1, 128'h00000008_00000018_00000028_00000038});
    check("t1_c0p6", {q[base+6].idx, q[base+6].d}, {3'd6, 128'h0});
    check("t1_c0p7", {q[base+7].idx, q[base+7].d}, {3'd7, 128'h0});
    check("t1_c7p3", {q[base+59].idx, q[base+59].d},
          {3'd3, 128'h0000000f_0000001f_0000002f_0000003f});
    for (int i = 0; i < 64; i++) exp_blk[i] = 32'(i);
    check_blk("t1", 1'b0, base);

    // 2: three blocks streamed with continuous valid
    do_reset();
    base = q.size();
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < 64; i++) send(6'(i), 32'(b * 1000 + i));
    wait_beats("t2", base + 192);
    repeat (10) @(posedge clk);
    #1;
    check("t2_count", 131'(q.size()), 131'(base + 192));
    bad = -1;
    for (int c = int'(q[base].cyc) - 70; c < int'(q[base].cyc) + 70; c++)
      if (bad < 0 && c > 0 && !acc_hist[c]) bad = acc_cnt_hist[c] - acc_cnt_hist[q[base].cyc - 80];
    check("t2_accept_drop", 131'(bad), 131'(128));
    check("t2_acc_low_b63", 131'(acc_hist[q[base+62].cyc]), 131'(0));
    check("t2_acc_high", 131'(acc_hist[q[base+63].cyc + 1]), 131'(1));
    bad = 0;
    for (int i = 0; i < 128; i++) if (q[base+i].cyc != q[base].cyc + i) bad++;
    check("t2_contig128", 131'(bad), 131'(0));
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 64; i++) exp_blk[i] = 32'(b * 1000 + i);
      check_blk($sformatf("t2_blk%0d", b), 1'b0, base + 64 * b);
    end

    // 3: reverse index order, then duplicate index 5
    do_reset();
    base = q.size();
    for (int i = 63; i >= 0; i--) send(6'(i), 32'(i * 3));
    wait_beats("t3", base + 64);
    for (int i = 0; i < 64; i++) exp_blk[i] = 32'(i * 3);
    check_blk("t3", 1'b0, base);
    base = q.size();
    send(6'd5, 32'd7);
    for (int i = 0; i < 63; i++) send(6'(i), (i == 5) ? 32'd9 : 32'(i + 100));
    wait_beats("t3d", base + 64);
    for (int i = 0; i < 64; i++) exp_blk[i] = (i == 5) ? 32'd9 : 32'(i + 100);
    check("t3_dup_c5p0", {q[base+40].idx, q[base+40].d}, exp_beat(40));
    check("t3_dup_c5p1", {q[base+41].idx, q[base+41].d}, exp_beat(41));
    check("t3_dup_val", 131'(q[base+40].d[127:96]), 131'(9));

    // 4: negative data, shift and saturation
    do_reset();
    base = q.size();
    bad = qs.size();
    for (int i = 0; i < 64; i++)
      send(6'(i), (i == 0) ? -32'sd5 : (i == 1) ? 32'h0001_0000 :
                  (i == 2) ? -32'sd70000 : 32'(i * 4));
    wait_beats("t4", base + 64);
    for (int i = 0; i < 64; i++) exp_blk[i] = 32'(i * 4);
    exp_blk[0] = 32'hffff_fffb;
`ifdef JPEG_IDCT_TRANSPOSE_SAT_EN
    exp_blk[1] = 32'h0000_7fff;
    exp_blk[2] = 32'hffff_8000;
`else
    exp_blk[1] = 32'h0001_0000;
    exp_blk[2] = -32'sd70000;
`endif
    check_blk("t4_main", 1'b0, base);
    for (int i = 0; i < 64; i++) exp_blk[i] = 32'(i);
    exp_blk[0] = -32'sd2;
    exp_blk[1] = 32'h0000_4000;
    exp_blk[2] = -32'sd17500;
    check("t4_shift_m5", 131'(qs[bad].d[127:96]), 131'(32'hffff_fffe));
    check_blk("t4_sh", 1'b1, bad);

    // 5: image restart after 30 samples
    do_reset();
    base = q.size();
    for (int i = 0; i < 30; i++) send(6'(i), 32'hdead_0000 + 32'(i));
    img_start = 1'b1;
    in_valid  = 1'b1;
    in_idx    = 6'd40;
    in_data   = 32'hbad0_bad0;
    @(posedge clk);
    #1;
    img_start = 1'b0;
    in_valid  = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    check("t5_no_output", 131'(q.size()), 131'(base));
    for (int i = 0; i < 64; i++) send(6'(i), 32'(500 + i));
    wait_beats("t5", base + 64);
    for (int i = 0; i < 64; i++) exp_blk[i] = 32'(500 + i);
    check_blk("t5", 1'b0, base);

    // 6: reset while replaying
    do_reset();
    base = q.size();
    for (int i = 0; i < 64; i++) send(6'(i), 32'(i + 7));
    for (int t = 0; t < 200 && q.size() < base + 20; t++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t6_valid", 131'(vld), 131'(0));
    check("t6_data", 131'({d0, d1, d2, d3}), 131'(0));
    check("t6_accept", 131'(acc), 131'(1));
    rst = 1'b0;
    n_rst = q.size();
    check("t6_beats_at_rst", 131'(n_rst), 131'(base + 21));
    repeat (100) @(posedge clk);
    #1;
    check("t6_no_residual", 131'(q.size()), 131'(n_rst));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
